// File: rtl/cpu_reg_pkg.sv
// rtl/cpu_reg_pkg.sv - shared widths and select encoding for the register bank and read mux
package cpu_reg_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int SEL_WIDTH  = 5;
    localparam int NUM_REGS   = 16;

    localparam logic [SEL_WIDTH-1:0] SEL_NONE = 5'd0;
    localparam logic [SEL_WIDTH-1:0] SEL_R0   = 5'd1;
    localparam logic [SEL_WIDTH-1:0] SEL_R1   = 5'd2;
    localparam logic [SEL_WIDTH-1:0] SEL_R2   = 5'd3;
    localparam logic [SEL_WIDTH-1:0] SEL_R3   = 5'd4;
    localparam logic [SEL_WIDTH-1:0] SEL_R4   = 5'd5;
    localparam logic [SEL_WIDTH-1:0] SEL_R5   = 5'd6;
    localparam logic [SEL_WIDTH-1:0] SEL_R6   = 5'd7;
    localparam logic [SEL_WIDTH-1:0] SEL_R7   = 5'd8;
    localparam logic [SEL_WIDTH-1:0] SEL_R8   = 5'd9;
    localparam logic [SEL_WIDTH-1:0] SEL_R9   = 5'd10;
    localparam logic [SEL_WIDTH-1:0] SEL_R10  = 5'd11;
    localparam logic [SEL_WIDTH-1:0] SEL_R11  = 5'd12;
    localparam logic [SEL_WIDTH-1:0] SEL_R12  = 5'd13;
    localparam logic [SEL_WIDTH-1:0] SEL_R13  = 5'd14;
    localparam logic [SEL_WIDTH-1:0] SEL_R14  = 5'd15;
    localparam logic [SEL_WIDTH-1:0] SEL_R15  = 5'd16;
    localparam logic [SEL_WIDTH-1:0] SEL_MAX  = 5'd16;

    function automatic logic sel_valid(input logic [SEL_WIDTH-1:0] sel);
        return (sel >= SEL_R0) && (sel <= SEL_MAX);
    endfunction

endpackage

// File: rtl/reg_bank_16x16_if.sv
// rtl/reg_bank_16x16_if.sv - write/control bus and status flags of the register bank
interface reg_bank_16x16_if;
    import cpu_reg_pkg::*;

    logic                  wr_en;
    logic [SEL_WIDTH-1:0]  wr_select;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  clear_all;
    logic                  clr_err;
    logic                  bad_sel_err;
    logic                  wr_ack;
    logic [SEL_WIDTH-1:0]  last_wr_sel;

    modport master (
        output wr_en, wr_select, wr_data, clear_all, clr_err,
        input  bad_sel_err, wr_ack, last_wr_sel
    );

    modport slave (
        input  wr_en, wr_select, wr_data, clear_all, clr_err,
        output bad_sel_err, wr_ack, last_wr_sel
    );

endinterface

// File: rtl/reg_write_decoder.sv
// rtl/reg_write_decoder.sv - select to one-hot write enable plus invalid-select flag
module reg_write_decoder
    import cpu_reg_pkg::*;
(
    input  logic                 wr_en,
    input  logic [SEL_WIDTH-1:0] wr_select,
    output logic [NUM_REGS-1:0]  wr_onehot,
    output logic                 sel_invalid
);

    always_comb begin
        wr_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_onehot[i] = wr_en && (wr_select == SEL_WIDTH'(i + 1));
        end
        sel_invalid = wr_en && !sel_valid(wr_select);
    end

endmodule

// File: rtl/reg_bank_16x16.sv
// rtl/reg_bank_16x16.sv - 16x16 register bank with clear, sticky bad-select flag and write trace
module reg_bank_16x16
    import cpu_reg_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    reg_bank_16x16_if.slave       bus,
    output logic [DATA_WIDTH-1:0] r0,
    output logic [DATA_WIDTH-1:0] r1,
    output logic [DATA_WIDTH-1:0] r2,
    output logic [DATA_WIDTH-1:0] r3,
    output logic [DATA_WIDTH-1:0] r4,
    output logic [DATA_WIDTH-1:0] r5,
    output logic [DATA_WIDTH-1:0] r6,
    output logic [DATA_WIDTH-1:0] r7,
    output logic [DATA_WIDTH-1:0] r8,
    output logic [DATA_WIDTH-1:0] r9,
    output logic [DATA_WIDTH-1:0] r10,
    output logic [DATA_WIDTH-1:0] r11,
    output logic [DATA_WIDTH-1:0] r12,
    output logic [DATA_WIDTH-1:0] r13,
    output logic [DATA_WIDTH-1:0] r14,
    output logic [DATA_WIDTH-1:0] r15
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_onehot;
    logic                  sel_invalid;
    logic                  wr_accept;

    reg_write_decoder u_dec (
        .wr_en       (bus.wr_en),
        .wr_select   (bus.wr_select),
        .wr_onehot   (wr_onehot),
        .sel_invalid (sel_invalid)
    );

    // clear_all suppresses the write entirely, including its ack and trace
    assign wr_accept = (|wr_onehot) && !bus.clear_all;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.clear_all)     regs[i] <= '0;
                else if (wr_onehot[i]) regs[i] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.wr_ack      <= 1'b0;
            bus.last_wr_sel <= SEL_NONE;
            bus.bad_sel_err <= 1'b0;
        end else begin
            bus.wr_ack <= wr_accept;
            if (wr_accept) bus.last_wr_sel <= bus.wr_select;
            // a new bad select outranks a same-cycle clear request
            if (sel_invalid)      bus.bad_sel_err <= 1'b1;
            else if (bus.clr_err) bus.bad_sel_err <= 1'b0;
        end
    end

    assign r0  = regs[0];
    assign r1  = regs[1];
    assign r2  = regs[2];
    assign r3  = regs[3];
    assign r4  = regs[4];
    assign r5  = regs[5];
    assign r6  = regs[6];
    assign r7  = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];
    assign r15 = regs[15];

endmodule

// File: tb/tb_reg_bank_16x16.sv
// tb/tb_reg_bank_16x16.sv - vector table, hand sequences and random run against a reference model
module tb_reg_bank_16x16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [15:0][15:0] rp;

    reg_bank_16x16_if bus();

    reg_bank_16x16 dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave),
        .r0(rp[0]),   .r1(rp[1]),   .r2(rp[2]),   .r3(rp[3]),
        .r4(rp[4]),   .r5(rp[5]),   .r6(rp[6]),   .r7(rp[7]),
        .r8(rp[8]),   .r9(rp[9]),   .r10(rp[10]), .r11(rp[11]),
        .r12(rp[12]), .r13(rp[13]), .r14(rp[14]), .r15(rp[15])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  sel;
        logic [15:0] data;
        logic        clr;
        logic        cerr;
        logic        exp_ack;
        logic        exp_err;
        logic [4:0]  exp_last;
        int          exp_idx;
        logic [15:0] exp_val;
    } vec_t;

    int total = 0;
    int bad = 0;

    logic [15:0] m_reg [16];
    logic        m_ack;
    logic        m_err;
    logic [4:0]  m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
        m_ack = 1'b0; m_err = 1'b0; m_last = 5'd0;
    endtask

    task automatic model_step(input logic we, input logic [4:0] sel, input logic [15:0] data,
                              input logic clr, input logic cerr);
        int  idx;
        logic ok;
        idx = int'(sel) - 1;
        ok  = (idx >= 0) && (idx < 16);
        if (clr) begin
            for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
            m_ack = 1'b0;
        end else if (we && ok) begin
            m_reg[idx] = data;
            m_ack = 1'b1;
            m_last = sel;
        end else begin
            m_ack = 1'b0;
        end
        if (we && !ok) m_err = 1'b1;
        else if (cerr) m_err = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [4:0] sel, input logic [15:0] data,
                         input logic clr, input logic cerr);
        bus.wr_en = we; bus.wr_select = sel; bus.wr_data = data;
        bus.clear_all = clr; bus.clr_err = cerr;
    endtask

    task automatic apply(input logic we, input logic [4:0] sel, input logic [15:0] data,
                         input logic clr, input logic cerr);
        drive(we, sel, data, clr, cerr);
        model_step(we, sel, data, clr, cerr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_r%0d", tag, i), 32'(rp[i]), 32'(m_reg[i]));
        chk({tag, "_ack"},  32'(bus.wr_ack),      32'(m_ack));
        chk({tag, "_err"},  32'(bus.bad_sel_err), 32'(m_err));
        chk({tag, "_last"}, 32'(bus.last_wr_sel), 32'(m_last));
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic [15:0] held;

        // vector table: write sweep, invalid selects, clear collision, back-to-back
        for (int k = 1; k <= 16; k++) begin
            v = '{1'b1, 5'(k), 16'hA000 + 16'(k), 1'b0, 1'b0, 1'b1, 1'b0, 5'(k), k - 1, 16'hA000 + 16'(k)};
            vecs.push_back(v);
        end
        vecs.push_back('{1'b1, 5'd0,  16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16, -1, 16'h0});
        vecs.push_back('{1'b1, 5'd17, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16, -1, 16'h0});
        vecs.push_back('{1'b1, 5'd31, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16, -1, 16'h0});
        vecs.push_back('{1'b1, 5'd0,  16'h8888, 1'b0, 1'b1, 1'b0, 1'b1, 5'd16, -1, 16'h0});
        vecs.push_back('{1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16, 0, 16'hA001});
        vecs.push_back('{1'b0, 5'd20, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 4, 16'hA005});
        vecs.push_back('{1'b1, 5'd3,  16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 5'd16, 2, 16'h0});
        vecs.push_back('{1'b1, 5'd20, 16'h4321, 1'b1, 1'b0, 1'b0, 1'b1, 5'd16, 0, 16'h0});
        vecs.push_back('{1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16, -1, 16'h0});
        vecs.push_back('{1'b1, 5'd16, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16, 15, 16'hFFFF});
        vecs.push_back('{1'b1, 5'd16, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16, 15, 16'h0001});

        // reset held while a write is requested
        model_reset();
        drive(1'b1, 5'd5, 16'hDEAD, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_model("rst");
        chk("rst_r4_direct", 32'(rp[4]), 32'h0);
        @(negedge clk);
        drive(1'b0, 5'd5, 16'hDEAD, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_model("rst_rel");

        foreach (vecs[n]) begin
            v = vecs[n];
            apply(v.we, v.sel, v.data, v.clr, v.cerr);
            chk($sformatf("vec%0d_ack", n),  32'(bus.wr_ack),      32'(v.exp_ack));
            chk($sformatf("vec%0d_err", n),  32'(bus.bad_sel_err), 32'(v.exp_err));
            chk($sformatf("vec%0d_last", n), 32'(bus.last_wr_sel), 32'(v.exp_last));
            if (v.exp_idx >= 0) chk($sformatf("vec%0d_reg", n), 32'(rp[v.exp_idx]), 32'(v.exp_val));
            check_model($sformatf("vec%0d", n));
        end

        // no bypass: a pending write is not visible before its edge
        held = rp[6];
        drive(1'b1, 5'd7, 16'hBEEF, 1'b0, 1'b0);
        #2;
        chk("no_bypass_r6", 32'(rp[6]), 32'(held));
        chk("no_comb_ack", 32'(bus.wr_ack), 32'(m_ack));
        model_step(1'b1, 5'd7, 16'hBEEF, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("latency_r6", 32'(rp[6]), 32'hBEEF);
        check_model("latency");

        // asynchronous reset between edges with a write pending
        apply(1'b1, 5'd9, 16'hCAFE, 1'b0, 1'b0);
        apply(1'b1, 5'd0, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 5'd4, 16'h5A5A, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk);
        #1;
        chk("async_rst_no_write_r3", 32'(rp[3]), 32'h0);
        @(negedge clk);
        drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            apply(($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 20)),
                  16'($urandom),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) == 0));
            check_model($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
